mem_stage: RTL and testbench

- Sits directly downstream of the integer/FPU execute unit; consumes its 32-bit result `d` together with the decoded opcode.
- For LW/LW_S/SW/SW_S, `d` is the byte effective address and this block performs a data-memory access. All other ops are passed straight through to writeback.
- Drives a synchronous single-port data BRAM with a fixed read latency.
- Presents a valid/ready writeback interface so execute and writeback can stall independently.

---
 rtl/mem_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage between execute and writeback.
//
// Loads (LW, LW_S) and stores (SW, SW_S) use the execute result alu_d as a byte
// address and access a synchronous single-port data RAM. All other ops pass
// alu_d straight to writeback. Writeback uses a registered valid/ready record.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   in_valid/in_ready   handshake from execute
//   is_sorf, op         op class and opcode (op only decoded when is_sorf == 00)
//   alu_d, store_data   execute result / byte address, store value
//   wb_en/wb_dst/wb_fpr register write intent from decode
//   mem_*               data RAM port (mem_rdata valid MEM_LATENCY cycles after mem_en)
//   out_*               writeback record, out_valid/out_ready handshake
//
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, a load/store with
// alu_d[1:0] != 0 skips the memory access and returns out_err = 1. When not
// defined, the low address bits are ignored and out_err is tied low.

module mem_stage #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            is_sorf,
    input  logic [5:0]            op,
    input  logic [31:0]           alu_d,
    input  logic [31:0]           store_data,
    input  logic                  wb_en,
    input  logic [4:0]            wb_dst,
    input  logic                  wb_fpr,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_we,
    output logic [4:0]            out_dst,
    output logic                  out_fpr,
    output logic                  out_err
);

    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLwS = 6'b110001;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpSwS = 6'b111001;

    // WAIT lasts MEM_LATENCY cycles; data is captured on its last one.
    localparam logic [2:0] LastCnt = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  out_we_q, out_we_d;
    logic [4:0]            out_dst_q, out_dst_d;
    logic                  out_fpr_q, out_fpr_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  load_q, load_d;
    logic [2:0]            cnt_q, cnt_d;

    logic is_load, is_store, do_load, do_store, accept;

    assign is_load  = (is_sorf == 2'b00) && ((op == OpLw) || (op == OpLwS));
    assign is_store = (is_sorf == 2'b00) && ((op == OpSw) || (op == OpSwS));

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic out_err_q, out_err_d;
    assign misaligned = (is_load || is_store) && (alu_d[1:0] != 2'b00);
    assign do_load    = is_load && !misaligned;
    assign do_store   = is_store && !misaligned;
    assign out_err    = out_err_q;
`else
    assign do_load  = is_load;
    assign do_store = is_store;
    assign out_err  = 1'b0;
`endif

    // RESP accepts a new op in the same cycle its record drains, so a PASS
    // stream sustains one result per cycle.
    assign in_ready = ((state_q == StIdle) || (state_q == StResp)) &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    state_d = (do_load || do_store) ? StIssue : StResp;
                end else if ((state_q == StResp) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StIssue: state_d = load_q ? StWait : StResp;
            StWait: begin
                if (cnt_q == LastCnt) begin
                    state_d = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = (state_d == StResp);
        out_data_d  = out_data_q;
        out_we_d    = out_we_q;
        out_dst_d   = out_dst_q;
        out_fpr_d   = out_fpr_q;
        mem_en_d    = (state_d == StIssue);
        mem_we_d    = accept && do_store;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_d      = load_q;
        cnt_d       = cnt_q;
`ifdef MEM_ALIGN_CHECK_EN
        out_err_d   = out_err_q;
`endif

        if (accept) begin
            // Stores never write a register; loads overwrite out_data later.
            out_data_d = alu_d;
            out_we_d   = wb_en && !is_store;
            out_dst_d  = wb_dst;
            out_fpr_d  = wb_fpr;
            load_d     = do_load;
            if (do_load || do_store) begin
                mem_addr_d = alu_d[ADDR_WIDTH+1:2];
            end
            if (do_store) begin
                mem_wdata_d = store_data;
            end
`ifdef MEM_ALIGN_CHECK_EN
            out_err_d = misaligned;
            if (misaligned) begin
                out_we_d = 1'b0;
            end
`endif
        end

        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LastCnt) begin
                out_data_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
            out_dst_q   <= '0;
            out_fpr_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            out_dst_q   <= out_dst_d;
            out_fpr_q   <= out_fpr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_q      <= load_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_we    = out_we_q;
    assign out_dst   = out_dst_q;
    assign out_fpr   = out_fpr_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with ADDR_WIDTH = 4 and MEM_LATENCY = 3, using a
// small behavioural data RAM whose read data appears MEM_LATENCY cycles after
// the mem_en cycle.

module tb_mem_stage;

    localparam int AW = 4;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    is_sorf;
    logic [5:0]    op;
    logic [31:0]   alu_d;
    logic [31:0]   store_data;
    logic          wb_en;
    logic [4:0]    wb_dst;
    logic          wb_fpr;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_we;
    logic [4:0]    out_dst;
    logic          out_fpr;
    logic          out_err;

    int n_chk = 0;
    int n_bad = 0;
    int wb_count = 0;
    int en_count = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .ADDR_WIDTH (AW),
        .MEM_LATENCY(ML)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_sorf   (is_sorf),
        .op        (op),
        .alu_d     (alu_d),
        .store_data(store_data),
        .wb_en     (wb_en),
        .wb_dst    (wb_dst),
        .wb_fpr    (wb_fpr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_we    (out_we),
        .out_dst   (out_dst),
        .out_fpr   (out_fpr),
        .out_err   (out_err)
    );

    // Data RAM model; contents preset to 0x1000_0000 + index while in reset.
    logic [31:0] mem     [1 << AW];
    logic [31:0] rd_pipe [ML];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (rstn && out_valid && out_ready) wb_count <= wb_count + 1;
        if (rstn && mem_en) en_count <= en_count + 1;
    end
    assign mem_rdata = rd_pipe[ML-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sorf, input logic [5:0] o,
                         input logic [31:0] d, input logic [31:0] sd, input logic we,
                         input logic [4:0] dst, input logic fpr);
        in_valid   = v;
        is_sorf    = sorf;
        op         = o;
        alu_d      = d;
        store_data = sd;
        wb_en      = we;
        wb_dst     = dst;
        wb_fpr     = fpr;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b01, 6'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Called after the accept edge; n counts edges from accept to out_valid.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int wb0;
        int en0;

        rstn      = 1'b0;
        out_ready = 1'b1;
        idle_in();
        repeat (3) cyc();
        rstn = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_out_we", out_we, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // PASS, then two back-to-back PASS ops
        drive(1'b1, 2'b01, 6'd0, 32'h5, 32'd0, 1'b1, 5'd8, 1'b0);
        cyc();
        drive(1'b1, 2'b10, 6'd0, 32'h11, 32'd0, 1'b1, 5'd1, 1'b1);
        check("pass_valid", out_valid, 1'b1);
        check("pass_data", out_data, 32'h5);
        check("pass_dst", out_dst, 5'd8);
        check("pass_we", out_we, 1'b1);
        check("pass_mem_en", mem_en, 1'b0);
        check("b2b_in_ready", in_ready, 1'b1);
        cyc();
        drive(1'b1, 2'b00, 6'b000000, 32'h22, 32'd0, 1'b0, 5'd2, 1'b0);
        check("b2b1_valid", out_valid, 1'b1);
        check("b2b1_data", out_data, 32'h11);
        check("b2b1_fpr", out_fpr, 1'b1);
        cyc();
        idle_in();
        check("b2b2_valid", out_valid, 1'b1);
        check("b2b2_data", out_data, 32'h22);
        check("b2b2_we", out_we, 1'b0);
        cyc();
        check("b2b_drain", out_valid, 1'b0);
        check("b2b_wb_count", wb_count, 3);

        // SW to byte address 0x10 -> word 4
        drive(1'b1, 2'b00, 6'b101011, 32'h10, 32'hDEADBEEF, 1'b1, 5'd4, 1'b0);
        cyc();
        idle_in();
        #1;
        check("sw_mem_en", mem_en, 1'b1);
        check("sw_mem_we", mem_we, 1'b1);
        check("sw_mem_addr", mem_addr, 32'd4);
        check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_busy", in_ready, 1'b0);
        cyc();
        check("sw_mem_en_off", mem_en, 1'b0);
        check("sw_valid", out_valid, 1'b1);
        check("sw_out_we", out_we, 1'b0);
        check("sw_out_data", out_data, 32'h10);
        cyc();
        check("sw_drain", out_valid, 1'b0);

        // LW_S from the same word
        drive(1'b1, 2'b00, 6'b110001, 32'h10, 32'd0, 1'b1, 5'd3, 1'b1);
        cyc();
        idle_in();
        check("lws_mem_en", mem_en, 1'b1);
        check("lws_mem_we", mem_we, 1'b0);
        wait_valid(n);
        check("lws_latency", n, 2 + ML);
        check("lws_data", out_data, 32'hDEADBEEF);
        check("lws_fpr", out_fpr, 1'b1);
        check("lws_we", out_we, 1'b1);
        check("lws_dst", out_dst, 5'd3);
        cyc();

        // Backpressure: record holds while out_ready is low; next op stays held
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'd0, 32'h77, 32'd0, 1'b1, 5'd9, 1'b0);
        cyc();
        drive(1'b1, 2'b01, 6'd0, 32'h88, 32'd0, 1'b1, 5'd10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 32'h77);
            check("bp_dst", out_dst, 5'd9);
            check("bp_in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        cyc();
        idle_in();
        check("bp_next_data", out_data, 32'h88);
        check("bp_next_dst", out_dst, 5'd10);
        cyc();
        check("bp_drain", out_valid, 1'b0);

        // Wrap: byte address 0x44 is word 17, i.e. word 1 of a 16-word RAM
        drive(1'b1, 2'b00, 6'b100011, 32'h44, 32'd0, 1'b1, 5'd5, 1'b0);
        cyc();
        idle_in();
        check("wrap_mem_en", mem_en, 1'b1);
        check("wrap_mem_addr", mem_addr, 32'd1);
        wait_valid(n);
        check("wrap_latency", n, 2 + ML);
        check("wrap_data", out_data, 32'h1000_0001);
        check("wrap_fpr", out_fpr, 1'b0);
        cyc();

        // Unaligned LW at 0x13
        en0 = en_count;
        drive(1'b1, 2'b00, 6'b100011, 32'h13, 32'd0, 1'b1, 5'd6, 1'b0);
        cyc();
        idle_in();
`ifdef MEM_ALIGN_CHECK_EN
        check("algn_mem_en", mem_en, 1'b0);
        check("algn_valid", out_valid, 1'b1);
        check("algn_err", out_err, 1'b1);
        check("algn_we", out_we, 1'b0);
        check("algn_data", out_data, 32'h13);
        cyc();
        check("algn_no_access", en_count, en0);
`else
        check("algn_mem_en", mem_en, 1'b1);
        check("algn_mem_addr", mem_addr, 32'd4);
        wait_valid(n);
        check("algn_latency", n, 2 + ML);
        check("algn_data", out_data, 32'hDEADBEEF);
        check("algn_err", out_err, 1'b0);
        check("algn_we", out_we, 1'b1);
        cyc();
`endif
        check("algn_drain", out_valid, 1'b0);

        // Reset while a load sits in WAIT: no writeback ever appears
        drive(1'b1, 2'b00, 6'b100011, 32'h8, 32'd0, 1'b1, 5'd7, 1'b0);
        cyc();
        idle_in();
        cyc();
        rstn = 1'b0;
        repeat (3) cyc();
        rstn = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_mem_en", mem_en, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        wb0 = wb_count;
        repeat (10) cyc();
        check("mrst_no_wb", wb_count, wb0);
        check("mrst_still_idle", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
